// File: rtl/imem_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : imem_pkg
//  Purpose  : Shared definitions for the instruction-memory loader and the
//             CPU instruction RAM: default geometry, the pad/end instruction
//             and the loader state encoding.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package imem_pkg;

  // Default instruction RAM geometry, shared with the CPU's instruction RAM
  localparam int unsigned IMEM_DEPTH  = 512;
  localparam int unsigned IMEM_ADDR_W = 9;
  localparam int unsigned IMEM_DATA_W = 32;

  // Instruction used to pad every location past the end of the program
  localparam logic [31:0] IMEM_END_WORD = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_DRAIN = 3'd2,
    ST_FILL  = 3'd3,
    ST_DONE  = 3'd4
  } imem_state_t;

endpackage
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
//  Module   : imem_loader
//  Purpose  : Streams machine-code words into instruction RAM from address 0,
//             pads the rest of the RAM with the end instruction and then
//             releases the CPU through CPU_RUN.
//  Ports    : CLK         - clock, rising edge
//             RESET_N     - synchronous active-low reset
//             START       - begin a load (honoured in IDLE / DONE only)
//             IN_VALID    - source offers IN_DATA
//             IN_DATA     - instruction word
//             IN_LAST     - final program word (qualified by handshake)
//             IN_READY    - loader accepts a word this cycle
//             RAM_WE      - instruction RAM write enable
//             RAM_ADDR    - instruction RAM write address
//             RAM_WDATA   - instruction RAM write data
//             CPU_RUN     - RAM image complete, CPU may fetch
//             WORD_COUNT  - program words stored in the last/current load
//             OVERFLOW    - sticky, program longer than the RAM
//  Revision : 1.0 - initial release
// ============================================================================
module imem_loader
  import imem_pkg::*;
#(
  parameter int unsigned        DEPTH    = IMEM_DEPTH,
  parameter int unsigned        ADDR_W   = IMEM_ADDR_W,
  parameter int unsigned        DATA_W   = IMEM_DATA_W,
  parameter logic [DATA_W-1:0]  END_WORD = DATA_W'(IMEM_END_WORD)
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              START,
  input  logic              IN_VALID,
  input  logic [DATA_W-1:0] IN_DATA,
  input  logic              IN_LAST,
  output logic              IN_READY,
  output logic              RAM_WE,
  output logic [ADDR_W-1:0] RAM_ADDR,
  output logic [DATA_W-1:0] RAM_WDATA,
  output logic              CPU_RUN,
  output logic [ADDR_W:0]   WORD_COUNT,
  output logic              OVERFLOW
);

  localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(DEPTH - 1);

  imem_state_t       r_state;
  imem_state_t       w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   r_word_count;
  logic              r_overflow;
  logic              r_cpu_run;
  logic              w_accept;
  logic              w_at_end;

  // Ready is purely a function of state so the source sees it without
  // depending on its own valid.
  assign IN_READY = (r_state == ST_LOAD) || (r_state == ST_DRAIN);
  assign w_accept = IN_VALID & IN_READY;
  assign w_at_end = (r_addr == c_last_addr);

  // Next state and zero-latency RAM write port
  always_comb begin
    w_next    = r_state;
    RAM_WE    = 1'b0;
    RAM_ADDR  = '0;
    RAM_WDATA = '0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (START) w_next = ST_LOAD;
      end
      ST_LOAD: begin
        if (w_accept) begin
          RAM_WE    = 1'b1;
          RAM_ADDR  = r_addr;
          RAM_WDATA = IN_DATA;
          if (IN_LAST)       w_next = w_at_end ? ST_DONE : ST_FILL;
          else if (w_at_end) w_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Excess words are accepted and dropped until the source ends
        if (w_accept && IN_LAST) w_next = ST_DONE;
      end
      ST_FILL: begin
        RAM_WE    = 1'b1;
        RAM_ADDR  = r_addr;
        RAM_WDATA = END_WORD;
        if (w_at_end) w_next = ST_DONE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      r_state      <= ST_IDLE;
      r_addr       <= '0;
      r_word_count <= '0;
      r_overflow   <= 1'b0;
      r_cpu_run    <= 1'b0;
    end else begin
      r_state   <= w_next;
      // Registered from next state so CPU_RUN is high for exactly the DONE cycles
      r_cpu_run <= (w_next == ST_DONE);
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (START) begin
            r_addr       <= '0;
            r_word_count <= '0;
            r_overflow   <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (w_accept) begin
            // Wraps to 0 on the overflow path; unused in DRAIN
            r_addr       <= r_addr + ADDR_W'(1);
            r_word_count <= r_word_count + (ADDR_W + 1)'(1);
            if (!IN_LAST && w_at_end) r_overflow <= 1'b1;
          end
        end
        ST_FILL: begin
          r_addr <= r_addr + ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign CPU_RUN    = r_cpu_run;
  assign WORD_COUNT = r_word_count;
  assign OVERFLOW   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_imem_loader
//  Purpose  : Self-checking bench for imem_loader. Acts as the instruction
//             RAM, drives program streams (fixed table, hand sequences and
//             randomised loads with stalls) and compares the captured RAM
//             image, timing and status against a simple reference model.
//  Ports    : none
//  Revision : 1.0 - initial release
// ============================================================================
module tb_imem_loader;
  import imem_pkg::*;

  localparam int          DEPTH  = 512;
  localparam int          ADDR_W = 9;
  localparam int          DATA_W = 32;
  localparam logic [31:0] PAD    = 32'hFFFF_FFFF;

  logic              CLK;
  logic              RESET_N;
  logic              START;
  logic              IN_VALID;
  logic [DATA_W-1:0] IN_DATA;
  logic              IN_LAST;
  logic              IN_READY;
  logic              RAM_WE;
  logic [ADDR_W-1:0] RAM_ADDR;
  logic [DATA_W-1:0] RAM_WDATA;
  logic              CPU_RUN;
  logic [ADDR_W:0]   WORD_COUNT;
  logic              OVERFLOW;

  imem_loader #(
    .DEPTH    (DEPTH),
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .END_WORD (PAD)
  ) dut (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .START      (START),
    .IN_VALID   (IN_VALID),
    .IN_DATA    (IN_DATA),
    .IN_LAST    (IN_LAST),
    .IN_READY   (IN_READY),
    .RAM_WE     (RAM_WE),
    .RAM_ADDR   (RAM_ADDR),
    .RAM_WDATA  (RAM_WDATA),
    .CPU_RUN    (CPU_RUN),
    .WORD_COUNT (WORD_COUNT),
    .OVERFLOW   (OVERFLOW)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int          n_cmp;
  int          n_fail;
  int          cyc;
  logic [31:0] prog[$];
  int          vpat[$];
  logic [31:0] ram[DEPTH];

  typedef struct {
    int n_words;
    int exp_count;
    int exp_ovf;
    int exp_run;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic capture();
    if (RAM_WE === 1'b1) ram[RAM_ADDR] = RAM_WDATA;
  endtask

  task automatic clear_ram();
    for (int i = 0; i < DEPTH; i++) ram[i] = 32'hDEAD_0000 | 32'(i);
  endtask

  // Loads the words in prog. Cycle numbering: START sampled at the end of
  // cycle 0, first load cycle is 1. exp_run < 0 means "model only".
  task automatic run_load(input int stall_pct, input bit poke_start, input int exp_run);
    int n, idx, last_acc, bad_wr, bad_rdy, bad_img, exp_run_m, exp_cnt, budget;
    bit v, first;
    logic [31:0] exp_w;
    n = prog.size();
    clear_ram();
    START = 1'b1; IN_VALID = 1'b0; IN_LAST = 1'b0; IN_DATA = '0;
    @(posedge CLK); #1;
    START = 1'b0;
    cyc = 1;
    check("start_cpu_run_low", 64'(CPU_RUN), 64'(0));
    check("start_count_clear", 64'(WORD_COUNT), 64'(0));
    check("start_ovf_clear", 64'(OVERFLOW), 64'(0));
    idx = 0; last_acc = 0; bad_wr = 0; bad_rdy = 0;
    while (idx < n && cyc < 8 * DEPTH) begin
      if (vpat.size() > 0) v = (vpat.pop_front() != 0);
      else                 v = ($urandom_range(99) >= 32'(stall_pct));
      IN_VALID = v;
      IN_DATA  = v ? prog[idx] : $urandom;
      IN_LAST  = v ? (idx == n - 1) : 1'($urandom_range(1));
      #1;
      if (IN_READY !== 1'b1) bad_rdy++;
      if (v && IN_READY === 1'b1) begin
        if (idx < DEPTH) begin
          if (RAM_WE !== 1'b1 || RAM_ADDR !== ADDR_W'(idx) || RAM_WDATA !== prog[idx]) bad_wr++;
        end else if (RAM_WE !== 1'b0) bad_wr++;
        last_acc = cyc;
        idx++;
      end else if (RAM_WE !== 1'b0) bad_wr++;
      capture();
      @(posedge CLK); #1;
      cyc++;
    end
    IN_VALID = 1'b0; IN_LAST = 1'b0; IN_DATA = '0;
    check("all_words_accepted", 64'(idx), 64'(n));
    check("load_write_errors", 64'(bad_wr), 64'(0));
    check("load_ready_errors", 64'(bad_rdy), 64'(0));
    budget = cyc + DEPTH + 8;
    bad_rdy = 0;
    first = 1'b1;
    while (CPU_RUN !== 1'b1 && cyc < budget) begin
      if (poke_start && first) START = 1'b1;
      first = 1'b0;
      #1;
      if (IN_READY !== 1'b0) bad_rdy++;
      capture();
      @(posedge CLK); #1;
      START = 1'b0;
      cyc++;
    end
    // Reference model: words land at 0..min(n,DEPTH)-1, pad after, one fill
    // cycle per padded location, DONE the cycle after the last write/accept.
    exp_run_m = last_acc + 1 + ((n < DEPTH) ? (DEPTH - n) : 0);
    exp_cnt   = (n < DEPTH) ? n : DEPTH;
    check("cpu_run_high", 64'(CPU_RUN), 64'(1));
    check("cpu_run_cycle", 64'(cyc), 64'(exp_run_m));
    if (exp_run >= 0) check("cpu_run_cycle_table", 64'(cyc), 64'(exp_run));
    check("fill_ready_errors", 64'(bad_rdy), 64'(0));
    check("word_count", 64'(WORD_COUNT), 64'(exp_cnt));
    check("overflow", 64'(OVERFLOW), 64'(n > DEPTH));
    bad_img = 0;
    for (int a = 0; a < DEPTH; a++) begin
      exp_w = (a < n) ? prog[a] : PAD;
      if (ram[a] !== exp_w) bad_img++;
    end
    check("ram_image_errors", 64'(bad_img), 64'(0));
  endtask

  initial begin
    n_cmp = 0; n_fail = 0; cyc = 0;
    RESET_N = 1'b0; START = 1'b0; IN_VALID = 1'b0; IN_DATA = '0; IN_LAST = 1'b0;

    vecs[0] = '{n_words: 1,   exp_count: 1,   exp_ovf: 0, exp_run: 513};
    vecs[1] = '{n_words: 3,   exp_count: 3,   exp_ovf: 0, exp_run: 513};
    vecs[2] = '{n_words: 511, exp_count: 511, exp_ovf: 0, exp_run: 513};
    vecs[3] = '{n_words: 512, exp_count: 512, exp_ovf: 0, exp_run: 513};
    vecs[4] = '{n_words: 513, exp_count: 512, exp_ovf: 1, exp_run: 514};
    vecs[5] = '{n_words: 515, exp_count: 512, exp_ovf: 1, exp_run: 516};

    // Reset state
    repeat (3) @(posedge CLK);
    #1;
    check("rst_in_ready", 64'(IN_READY), 64'(0));
    check("rst_ram_we", 64'(RAM_WE), 64'(0));
    check("rst_ram_addr", 64'(RAM_ADDR), 64'(0));
    check("rst_ram_wdata", 64'(RAM_WDATA), 64'(0));
    check("rst_cpu_run", 64'(CPU_RUN), 64'(0));
    check("rst_word_count", 64'(WORD_COUNT), 64'(0));
    check("rst_overflow", 64'(OVERFLOW), 64'(0));
    RESET_N = 1'b1;

    // IDLE ignores an offered word
    IN_VALID = 1'b1; IN_DATA = 32'h1111_2222; IN_LAST = 1'b1;
    #1;
    check("idle_ready_low", 64'(IN_READY), 64'(0));
    check("idle_no_write", 64'(RAM_WE), 64'(0));
    @(posedge CLK); #1;
    IN_VALID = 1'b0; IN_LAST = 1'b0;
    check("idle_cpu_run_low", 64'(CPU_RUN), 64'(0));
    check("idle_count_zero", 64'(WORD_COUNT), 64'(0));

    // Short program, START poked during FILL (ignored)
    prog = '{32'h2001_0005, 32'h2002_0007, 32'h0022_1820};
    run_load(0, 1'b1, 513);

    // Restart from DONE with a 1-word program
    prog = '{32'h1234_5678};
    run_load(0, 1'b0, 513);

    // Stalls: valid 1,0,0,1,1 -> accepts in cycles 1,4,5
    prog = '{32'hAAAA_0001, 32'hAAAA_0002, 32'hAAAA_0003};
    vpat = '{1, 0, 0, 1, 1};
    run_load(0, 1'b0, 515);
    vpat.delete();

    // Table of program lengths around the RAM size
    for (int t = 0; t < 6; t++) begin
      prog.delete();
      for (int i = 0; i < vecs[t].n_words; i++) prog.push_back({16'(i), 16'hA5C3 ^ 16'(t)});
      run_load(0, 1'b0, vecs[t].exp_run);
      check("table_word_count", 64'(WORD_COUNT), 64'(vecs[t].exp_count));
      check("table_overflow", 64'(OVERFLOW), 64'(vecs[t].exp_ovf));
    end

    // Reset mid-load after 2 of 5 words
    START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    for (int i = 0; i < 2; i++) begin
      IN_VALID = 1'b1; IN_DATA = 32'h5555_0000 | 32'(i); IN_LAST = 1'b0;
      @(posedge CLK); #1;
    end
    IN_VALID = 1'b0;
    check("pre_reset_count", 64'(WORD_COUNT), 64'(2));
    RESET_N = 1'b0;
    @(posedge CLK); #1;
    check("midrst_in_ready", 64'(IN_READY), 64'(0));
    check("midrst_cpu_run", 64'(CPU_RUN), 64'(0));
    check("midrst_word_count", 64'(WORD_COUNT), 64'(0));
    check("midrst_overflow", 64'(OVERFLOW), 64'(0));
    RESET_N = 1'b1;
    prog = '{32'h0BAD_0001, 32'h0BAD_0002, 32'h0BAD_0003, 32'h0BAD_0004, 32'h0BAD_0005};
    run_load(0, 1'b0, 513);

    // Randomised loads with random stalls against the model
    for (int r = 0; r < 6; r++) begin
      int n;
      n = int'($urandom_range(520, 1));
      prog.delete();
      for (int i = 0; i < n; i++) prog.push_back($urandom);
      run_load(int'($urandom_range(60, 0)), 1'($urandom_range(1)), -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/imem_loader.md
# imem_loader

Program loader upstream of the pipelined CPU. Accepts a stream of 32-bit machine-code words over a valid/ready handshake, writes them into instruction RAM from address 0, and pads every remaining location with the end instruction. When the RAM image is complete it raises `CPU_RUN`, which releases the CPU to fetch. This replaces testbench-side direct RAM preloading with a synthesizable path.

## Interface
Parameters:
- `DEPTH`, 512: instruction RAM words.
- `ADDR_W`, 9: RAM address width, equal to log2(DEPTH).
- `DATA_W`, 32: instruction width.
- `END_WORD`, 32'hFFFF_FFFF: pad/end instruction.

Ports:
- `CLK`  in  1: sole clock, rising edge.
- `RESET_N`  in  1: synchronous, active-low reset.
- `START`  in  1: begin a load; sampled in IDLE or DONE only.
- `IN_VALID`  in  1: source offers `IN_DATA`.
- `IN_DATA`  in  DATA_W: instruction word.
- `IN_LAST`  in  1: marks the final program word; qualified by the handshake.
- `IN_READY`  out  1: loader accepts a word this cycle.
- `RAM_WE`  out  1: instruction RAM write enable.
- `RAM_ADDR`  out  ADDR_W: write address.
- `RAM_WDATA`  out  DATA_W: write data.
- `CPU_RUN`  out  1: RAM image complete. CPU is held while this is low.
- `WORD_COUNT`  out  ADDR_W+1: program words stored in the last or current load.
- `OVERFLOW`  out  1: sticky. Set when the program exceeds DEPTH words.

## Operation
- States are IDLE, LOAD, DRAIN, FILL and DONE. `addr` is an ADDR_W-bit register.
- **IDLE**
  - `IN_READY` = 0.
  - On `START`: go to LOAD; clear `addr`, `WORD_COUNT` and `OVERFLOW`.
- **LOAD**
  - `IN_READY` = 1.
  - A handshake (`IN_VALID` & `IN_READY`) drives `RAM_WE` = 1, `RAM_ADDR` = `addr`, `RAM_WDATA` = `IN_DATA`; then `addr`++ and `WORD_COUNT`++.
  - Handshake with `IN_LAST` and `addr` < DEPTH-1: go to FILL.
  - Handshake with `IN_LAST` and `addr` = DEPTH-1: go to DONE (no padding needed).
  - Handshake without `IN_LAST` and `addr` = DEPTH-1: set `OVERFLOW` and go to DRAIN. `addr` wraps to 0 but is unused there.
- **DRAIN**
  - `IN_READY` = 1, `RAM_WE` = 0. Accepted words are discarded.
  - Handshake with `IN_LAST`: go to DONE.
- **FILL**
  - `IN_READY` = 0.
  - Every cycle: `RAM_WE` = 1, `RAM_WDATA` = END_WORD, `RAM_ADDR` = `addr`, then `addr`++.
  - After writing `addr` = DEPTH-1: go to DONE.
- **DONE**
  - `CPU_RUN` = 1, `IN_READY` = 0.
  - `START` restarts: go to LOAD, `CPU_RUN` falls the next cycle, counters clear.
- `START` in LOAD, DRAIN or FILL is ignored.
- `IN_LAST` without `IN_VALID` is ignored. A program is at least one word.
- When `RAM_WE` = 0, `RAM_ADDR` and `RAM_WDATA` are don't-care; the implementation drives 0.

## Timing
- Reset values:
  - state IDLE, `addr` 0, `WORD_COUNT` 0, `OVERFLOW` 0, `CPU_RUN` 0.
  - `IN_READY` 0, `RAM_WE` 0, `RAM_ADDR` 0, `RAM_WDATA` 0.
- `IN_READY`, `RAM_WE`, `RAM_ADDR` and `RAM_WDATA` are combinational from state, `addr` and the handshake inputs. The RAM write happens in the same cycle as the handshake: zero latency.
- `CPU_RUN`, `WORD_COUNT` and `OVERFLOW` are registered.
- Reference timeline: `START` in cycle 0, N < DEPTH words streamed back-to-back.
  - Words accepted in cycles 1..N.
  - FILL writes in cycles N+1..DEPTH.
  - `CPU_RUN` = 1 from cycle DEPTH+1.
- Source stalls (`IN_VALID` = 0) insert cycles without writes; `addr` holds.
- `RESET_N` low mid-load: all registers return to reset values on that edge. RAM contents already written are not restored. The CPU stays held because `CPU_RUN` = 0.

## Structure
- Shared package `imem_pkg` holds:
  - the state enum (IDLE, LOAD, DRAIN, FILL, DONE);
  - `END_WORD`;
  - the default DEPTH/ADDR_W/DATA_W constants, also used by the CPU's instruction RAM.
- No sub-module: one flat FSM plus the address and word counters.
- The CPU top ties its hold/reset to `CPU_RUN`.

## Test plan
- **Short program:** reset, `START`, 3 words 0x2001_0005, 0x2002_0007, 0x0022_1820 (last) back-to-back.
  - RAM[0..2] hold those words; RAM[3..511] = 0xFFFF_FFFF.
  - `WORD_COUNT` = 3; `CPU_RUN` rises at cycle 513.
- **Exact fit:** 512 words, `IN_LAST` on the 512th.
  - No FILL cycles; `CPU_RUN` at cycle 513; `OVERFLOW` = 0.
- **Overflow:** 515 words, `IN_LAST` on the 515th.
  - RAM[511] = word 511, words 512-514 discarded.
  - `OVERFLOW` = 1, `WORD_COUNT` = 512, `CPU_RUN` = 1.
- **Stalls:** `IN_VALID` toggles 1,0,0,1,1 over a 3-word load.
  - Writes occur only on handshake cycles at addresses 0,1,2; no write in stall cycles.
- **Reset mid-load:** `RESET_N` = 0 after 2 of 5 words.
  - Next cycle: `IN_READY` = 0, `CPU_RUN` = 0, `WORD_COUNT` = 0.
  - A new `START` reloads from address 0.
- **Ignored START, then reload:** `START` asserted during FILL is ignored. A second `START` in DONE drops `CPU_RUN` the next cycle and a 1-word reload pads RAM[1..511].
